reg_chain_swap: RTL and testbench
=================================

Name: reg_chain_swap

Overview:
Parametrised successor of the two-register blocking/non-blocking swap cell. Holds N channels of W-bit registers, loads them in parallel, then applies a selected permutation for a programmed number of clock steps. Sits as a small datapath utility behind any controller that needs rotate, shift, pair-swap or broadcast of a register file, with start/busy/done handshake.

Parameters:
N, 4, channel count (>=2)
W, 8, bits per channel
STEP_W, 8, width of step-count input

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start_i  input  1  request; sampled only in IDLE
mode_i  input  2  permutation select, sampled with start_i
steps_i  input  STEP_W  number of steps, sampled with start_i
data_i  input  N*W  parallel load value; channel k at bits [k*W +: W]
data_o  output  N*W  current channel registers, same packing
busy_o  output  1  high while in RUN
done_o  output  1  one-cycle completion pulse

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset: state=IDLE, all channels=0, step counter=0, busy_o=0, done_o=0, data_o=0. Reset asserted mid-RUN aborts immediately; no done_o.
- States: IDLE, RUN, DONE.
- IDLE: start_i=1 at an edge -> load ch[k]=data_i[k], latch mode and steps; next state RUN if steps_i!=0, else DONE (data unchanged). start_i=0 -> stay.
- RUN: busy_o=1. Each edge applies one step and decrements the counter; the edge applying the final step moves to DONE. Permutation per step; all channels update simultaneously from pre-edge values (non-blocking semantics):
  - 2'b00 ROTATE: ch[k]<=ch[k-1], ch[0]<=ch[N-1].
  - 2'b01 SHIFT: ch[k]<=ch[k-1], ch[0]<=0.
  - 2'b10 PAIRSWAP: ch[2j]<=ch[2j+1], ch[2j+1]<=ch[2j]; for odd N, ch[N-1] holds.
  - 2'b11 BROADCAST: all ch[k]<=ch[0]; exactly one step taken regardless of steps_i (steps_i!=0).
- DONE: done_o=1 for exactly one cycle, busy_o=0; unconditionally returns to IDLE. start_i in RUN or DONE is ignored (not queued).
- Latency: start edge T loads; result after S steps is on data_o after edge T+S; done_o high during cycle after edge T+S. steps_i=0: done_o during cycle after edge T.
- data_o is registered and always reflects the channels; it holds the result in IDLE until the next start.
- Counter is STEP_W bits, no wrap: max steps = 2^STEP_W-1.
- mode_i/steps_i/data_i changes during RUN have no effect.

Decomposition:
- Package reg_chain_pkg: mode constants (MODE_ROTATE, MODE_SHIFT, MODE_PAIRSWAP, MODE_BROADCAST), state encoding (IDLE/RUN/DONE).
- One sub-module reg_chain_step: purely combinational next-vector function (mode, N*W in -> N*W out), parametrised by N and W; top holds FSM, counter and registers.

Test Plan:
- N=4,W=8, data_i={44,33,22,11} (ch3..ch0), ROTATE, steps=1 -> data_o={33,22,11,44}, done_o one pulse 2 cycles after start edge; steps=4 -> data_o returns to {44,33,22,11}.
- SHIFT, steps=2 -> data_o={22,11,00,00}; busy_o high exactly 2 cycles.
- PAIRSWAP steps=1 -> {33,44,11,22}; N=5 variant with ch4=55 -> ch4 stays 55.
- BROADCAST, steps=5 -> {11,11,11,11} after one step, busy_o high 1 cycle; steps=0 any mode -> no busy, done_o next cycle, data_o=loaded value.
- start_i held high through RUN and DONE -> ignored; new operation begins only on start seen in IDLE.
- rst_n low mid-RUN (step 2 of 4, ROTATE) -> data_o=0, busy_o=0, done_o never pulses; after release, a normal start completes correctly.

Source files
------------

// File: rtl/reg_chain_pkg.sv
// reg_chain_pkg: shared mode and state encodings for the register-chain permutation block
package reg_chain_pkg;

   typedef enum logic [1:0] {
      MODE_ROTATE    = 2'b00,
      MODE_SHIFT     = 2'b01,
      MODE_PAIRSWAP  = 2'b10,
      MODE_BROADCAST = 2'b11
   } mode_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_e;

endpackage

// File: rtl/reg_chain_swap_if.sv
// reg_chain_swap_if: start/busy/done handshake plus parallel load and readback bus
interface reg_chain_swap_if #(
   parameter int N      = 4,
   parameter int W      = 8,
   parameter int STEP_W = 8
);
   logic              start_i;
   logic [1:0]        mode_i;
   logic [STEP_W-1:0] steps_i;
   logic [N*W-1:0]    data_i;
   logic [N*W-1:0]    data_o;
   logic              busy_o;
   logic              done_o;

   modport master (
      output start_i, mode_i, steps_i, data_i,
      input  data_o, busy_o, done_o
   );

   modport slave (
      input  start_i, mode_i, steps_i, data_i,
      output data_o, busy_o, done_o
   );
endinterface

// File: rtl/reg_chain_step.sv
// reg_chain_step: combinational one-step permutation of an N-channel register vector
module reg_chain_step
   import reg_chain_pkg::*;
#(
   parameter int N = 4,
   parameter int W = 8
) (
   input  mode_e          mode_i,
   input  logic [N*W-1:0] vec_i,
   output logic [N*W-1:0] vec_o
);

   for (genvar k = 0; k < N; k++) begin : g_ch
      logic [W-1:0] rot, shf, pair;
      if (k == 0) begin : g_head
         assign rot = vec_i[(N-1)*W +: W];
         assign shf = '0;
      end else begin : g_body
         assign rot = vec_i[(k-1)*W +: W];
         assign shf = vec_i[(k-1)*W +: W];
      end
      if (k % 2 == 1) begin : g_odd
         assign pair = vec_i[(k-1)*W +: W];
      end else if (k == N - 1) begin : g_last
         // unpaired top channel of an odd-sized chain keeps its value
         assign pair = vec_i[k*W +: W];
      end else begin : g_even
         assign pair = vec_i[(k+1)*W +: W];
      end
      assign vec_o[k*W +: W] = (mode_i == MODE_ROTATE)   ? rot  :
                               (mode_i == MODE_SHIFT)    ? shf  :
                               (mode_i == MODE_PAIRSWAP) ? pair : vec_i[W-1:0];
   end

endmodule

// File: rtl/reg_chain_swap.sv
// reg_chain_swap: N-channel register file that loads in parallel then permutes for a counted number of steps
module reg_chain_swap
   import reg_chain_pkg::*;
#(
   parameter int N      = 4,
   parameter int W      = 8,
   parameter int STEP_W = 8
) (
   input logic             clk,
   input logic             rst_n,
   reg_chain_swap_if.slave bus
);

   state_e            state_q, state_d;
   mode_e             mode_q, mode_d;
   logic [STEP_W-1:0] cnt_q, cnt_d;
   logic [N*W-1:0]    data_q, data_d;
   logic [N*W-1:0]    step_vec;
   mode_e             mode_in;

   assign mode_in = mode_e'(bus.mode_i);

   reg_chain_step #(.N(N), .W(W)) u_step (
      .mode_i(mode_q),
      .vec_i (data_q),
      .vec_o (step_vec)
   );

   // next-state, step counter and channel update; broadcast is idempotent so it runs one step only
   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      case (state_q)
         IDLE: if (bus.start_i) begin
            data_d  = bus.data_i;
            mode_d  = mode_in;
            cnt_d   = (mode_in == MODE_BROADCAST && bus.steps_i != '0) ? STEP_W'(1) : bus.steps_i;
            state_d = (bus.steps_i != '0) ? RUN : DONE;
         end
         RUN: begin
            data_d  = step_vec;
            cnt_d   = cnt_q - STEP_W'(1);
            state_d = (cnt_q == STEP_W'(1)) ? DONE : RUN;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // state, latched mode, counter and channel registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         mode_q  <= MODE_ROTATE;
         cnt_q   <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
      end
   end

   assign bus.data_o = data_q;
   assign bus.busy_o = (state_q == RUN);
   assign bus.done_o = (state_q == DONE);

endmodule

// File: tb/tb_reg_chain_swap.sv
// tb_reg_chain_swap: N=4 and N=5 instances driven in lockstep against a per-cycle expectation plan
module tb_reg_chain_swap;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start;
   logic [1:0]  mode;
   logic [7:0]  steps;
   logic [39:0] din;

   always #5 clk = ~clk;

   reg_chain_swap_if #(.N(4), .W(8), .STEP_W(8)) b4();
   reg_chain_swap_if #(.N(5), .W(8), .STEP_W(8)) b5();

   assign b4.start_i = start;
   assign b5.start_i = start;
   assign b4.mode_i  = mode;
   assign b5.mode_i  = mode;
   assign b4.steps_i = steps;
   assign b5.steps_i = steps;
   assign b4.data_i  = din[31:0];
   assign b5.data_i  = din;

   reg_chain_swap #(.N(4), .W(8), .STEP_W(8)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));
   reg_chain_swap #(.N(5), .W(8), .STEP_W(8)) dut5 (.clk(clk), .rst_n(rst_n), .bus(b5));

   typedef struct {
      logic [39:0] d4;
      logic [39:0] d5;
      logic        busy;
      logic        done;
   } exp_t;

   exp_t plan[$];
   exp_t cur;
   int   passed = 0;
   int   total  = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
   endtask

   // one permutation step over n byte channels, written from the mode definitions
   function automatic logic [39:0] mstep(input logic [1:0] m, input logic [39:0] v, input int n);
      logic [7:0]  c[5];
      logic [39:0] r;
      r = '0;
      for (int k = 0; k < n; k++) c[k] = v[k*8 +: 8];
      for (int k = 0; k < n; k++) begin
         logic [7:0] x;
         case (m)
            2'b00:   x = c[(k + n - 1) % n];
            2'b01:   x = (k == 0) ? 8'h00 : c[k-1];
            2'b10:   x = ((k ^ 1) < n) ? c[k ^ 1] : c[k];
            default: x = c[0];
         endcase
         r[k*8 +: 8] = x;
      end
      return r;
   endfunction

   // reference model: on an accepted start, precompute the whole per-edge expectation sequence
   initial begin
      cur.d4 = '0; cur.d5 = '0; cur.busy = 1'b0; cur.done = 1'b0;
      forever begin
         @(posedge clk);
         if (!rst_n) begin
            plan.delete();
            cur.d4 = '0; cur.d5 = '0; cur.busy = 1'b0; cur.done = 1'b0;
         end else begin
            if (plan.size() == 0 && start) begin
               int   s;
               exp_t e;
               s = (steps == 0) ? 0 : (mode == 2'b11) ? 1 : int'(steps);
               e.d4 = {8'h00, din[31:0]};
               e.d5 = din;
               e.busy = (s > 0);
               e.done = (s == 0);
               plan.push_back(e);
               for (int i = 1; i <= s; i++) begin
                  e.d4 = mstep(mode, e.d4, 4);
                  e.d5 = mstep(mode, e.d5, 5);
                  e.busy = (i < s);
                  e.done = (i == s);
                  plan.push_back(e);
               end
               e.busy = 1'b0;
               e.done = 1'b0;
               plan.push_back(e);
            end
            if (plan.size() != 0) cur = plan.pop_front();
         end
      end
   end

   // per-cycle comparison of both instances against the model
   initial forever begin
      @(negedge clk);
      chk("data4", 64'(b4.data_o), 64'(cur.d4[31:0]));
      chk("data5", 64'(b5.data_o), 64'(cur.d5));
      chk("busy", {b4.busy_o, b5.busy_o}, {cur.busy, cur.busy});
      chk("done", {b4.done_o, b5.done_o}, {cur.done, cur.done});
   end

   // issue one operation from negedge+1; returns negedges until done and busy cycles seen
   task automatic op(input logic [1:0] m, input logic [7:0] s, input logic [39:0] d,
                     input bit hold, output int waits, output int busy_n);
      start = 1'b1; mode = m; steps = s; din = d;
      waits = 0; busy_n = 0;
      while (waits < 300) begin
         @(negedge clk);
         waits++;
         if (b4.done_o) break;
         if (b4.busy_o) busy_n++;
         #1 if (!hold) start = 1'b0;
      end
      chk("done_seen", 64'(b4.done_o), 64'd1);
      #1 if (!hold) start = 1'b0;
   endtask

   task automatic gap();
      @(negedge clk);
      #1;
   endtask

   localparam logic [39:0] LOAD = {8'd55, 8'd44, 8'd33, 8'd22, 8'd11};

   initial begin
      int w, b;
      start = 1'b0; mode = 2'b00; steps = '0; din = '0;
      repeat (2) @(negedge clk);
      chk("rst_data", 64'(b4.data_o), 64'd0);
      chk("rst_busy_done", {b4.busy_o, b4.done_o}, 2'b00);
      #1 rst_n = 1'b1;
      gap();

      op(2'b00, 8'd1, LOAD, 1'b0, w, b);
      chk("rot1_data", 64'(b4.data_o), {32'd0, 8'd33, 8'd22, 8'd11, 8'd44});
      chk("rot1_lat", 64'(w), 64'd2);
      gap();
      op(2'b00, 8'd4, LOAD, 1'b0, w, b);
      chk("rot4_data", 64'(b4.data_o), {32'd0, 8'd44, 8'd33, 8'd22, 8'd11});
      chk("rot4_busy", 64'(b), 64'd4);
      gap();
      op(2'b01, 8'd2, LOAD, 1'b0, w, b);
      chk("shift2_data", 64'(b4.data_o), {32'd0, 8'd22, 8'd11, 8'd0, 8'd0});
      chk("shift2_busy", 64'(b), 64'd2);
      gap();
      op(2'b10, 8'd1, LOAD, 1'b0, w, b);
      chk("pair_data4", 64'(b4.data_o), {32'd0, 8'd33, 8'd44, 8'd11, 8'd22});
      chk("pair_data5", 64'(b5.data_o), {24'd0, 8'd55, 8'd33, 8'd44, 8'd11, 8'd22});
      gap();
      op(2'b11, 8'd5, LOAD, 1'b0, w, b);
      chk("bcast_data", 64'(b4.data_o), {32'd0, 8'd11, 8'd11, 8'd11, 8'd11});
      chk("bcast_busy", 64'(b), 64'd1);
      gap();
      op(2'b00, 8'd0, {8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, 1'b0, w, b);
      chk("zero_lat", 64'(w), 64'd1);
      chk("zero_busy", 64'(b), 64'd0);
      chk("zero_data", 64'(b4.data_o), {32'd0, 8'd4, 8'd3, 8'd2, 8'd1});
      gap();
      op(2'b11, 8'd0, LOAD, 1'b0, w, b);
      chk("zero_bc_lat", 64'(w), 64'd1);
      gap();

      op(2'b00, 8'd2, LOAD, 1'b1, w, b);
      chk("hold_data", 64'(b4.data_o), {32'd0, 8'd22, 8'd11, 8'd44, 8'd33});
      chk("hold_busy", 64'(b), 64'd2);
      @(negedge clk);
      chk("hold_idle", {b4.busy_o, b4.done_o}, 2'b00);
      chk("hold_keep", 64'(b4.data_o), {32'd0, 8'd22, 8'd11, 8'd44, 8'd33});
      #1 start = 1'b0;
      gap();

      start = 1'b1; mode = 2'b00; steps = 8'd4; din = LOAD;
      @(negedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("abort_data", 64'(b4.data_o), 64'd0);
      chk("abort_busy", {b4.busy_o, b5.busy_o}, 2'b00);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("abort_nodone", {b4.done_o, b5.done_o}, 2'b00);
      end
      #1 rst_n = 1'b1;
      gap();
      op(2'b00, 8'd1, LOAD, 1'b0, w, b);
      chk("post_rst_data", 64'(b4.data_o), {32'd0, 8'd33, 8'd22, 8'd11, 8'd44});
      gap();

      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         #1;
         start = ($urandom_range(0, 2) == 0);
         mode  = 2'($urandom);
         steps = ($urandom_range(0, 15) == 0) ? 8'($urandom) : 8'($urandom_range(0, 6));
         din   = {8'($urandom), 32'($urandom)};
         rst_n = ($urandom_range(0, 199) != 0);
      end
      #1 rst_n = 1'b1;
      start = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
